// File: rtl/kw_clock_div_prog_if.sv
// Divisor configuration handshake between a controller (master) and the
// programmable clock divider (slave).
interface kw_clock_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/kw_clock_div_prog.sv
// Runtime-programmable integer clock divider with a registered, glitch-free
// output. Divisor and enable changes take effect only at period boundaries.
module kw_clock_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                 i_clock,
    input  logic                 reset,
    input  logic                 testmode,
    input  logic                 en,
    kw_clock_div_prog_if.slave   cfg,
    output logic                 o_clock,
    output logic                 o_tick,
    output logic                 o_running,
    output logic [WIDTH-1:0]     o_div
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_inc;
    logic             at_boundary;
    logic             accept;
    logic             bad_div;

    assign half        = cur_div_q >> 1;
    assign cnt_inc     = cnt_q + WIDTH'(1);
    assign at_boundary = (cnt_q == (cur_div_q - WIDTH'(1)));
    assign accept      = cfg.cfg_valid & ~pend_vld_q;
    assign bad_div     = (cfg.cfg_div < WIDTH'(2));

    // State register and datapath registers
    always_ff @(posedge i_clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_div_q  <= WIDTH'(DEFAULT_DIV);
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en) state_d = ST_RUN;
            ST_RUN:  if (at_boundary && !en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        err_d      = accept & bad_div;

        case (state_q)
            ST_IDLE: begin
                clk_d = 1'b0;
                // A divisor left pending by a stop is applied here, since
                // IDLE behaves as a permanent period boundary.
                if (pend_vld_q) begin
                    cur_div_d  = pend_div_q;
                    pend_vld_d = 1'b0;
                end
                if (accept && !bad_div) begin
                    cur_div_d = cfg.cfg_div;
                end
                if (en) begin
                    cnt_d  = '0;
                    clk_d  = 1'b1;
                    tick_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!at_boundary) begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < half);
                end else begin
                    if (pend_vld_q) begin
                        cur_div_d  = pend_div_q;
                        pend_vld_d = 1'b0;
                    end
                    cnt_d = '0;
                    if (en) begin
                        clk_d  = 1'b1;
                        tick_d = 1'b1;
                    end else begin
                        clk_d = 1'b0;
                    end
                end
                // accept implies pend_vld_q==0, so no conflict with the boundary apply
                if (accept && !bad_div) begin
                    pend_div_d = cfg.cfg_div;
                    pend_vld_d = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
                clk_d = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        cfg.cfg_ready = ~pend_vld_q;
        cfg.cfg_err   = err_q;
        o_running     = (state_q == ST_RUN);
        o_tick        = tick_q;
        o_div         = cur_div_q;
        o_clock       = testmode ? i_clock : clk_q;
    end

endmodule

// File: tb/tb_kw_clock_div_prog.sv
// Directed self-checking bench for the programmable clock divider.
module tb_kw_clock_div_prog;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             testmode;
    logic             en;
    logic             o_clock;
    logic             o_tick;
    logic             o_running;
    logic [WIDTH-1:0] o_div;

    int checks;
    int failures;

    kw_clock_div_prog_if #(.WIDTH(WIDTH)) cfg_if ();

    kw_clock_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
        .i_clock   (clk),
        .reset     (reset),
        .testmode  (testmode),
        .en        (en),
        .cfg       (cfg_if.slave),
        .o_clock   (o_clock),
        .o_tick    (o_tick),
        .o_running (o_running),
        .o_div     (o_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Walk cycles first..n-1 of a period of n, checking duty and tick.
    task automatic run_cycles(input int n, input int first);
        for (int i = first; i < n; i++) begin
            step();
            check_eq($sformatf("clk_n%0d_c%0d", n, i), 32'(o_clock), 32'(i < n / 2));
            check_eq($sformatf("tick_n%0d_c%0d", n, i), 32'(o_tick), 32'(i == 0));
        end
    endtask

    task automatic program_idle(input logic [WIDTH-1:0] d);
        check_eq("prog_ready", 32'(cfg_if.cfg_ready), 32'd1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = d;
        step();
        cfg_if.cfg_valid = 1'b0;
        check_eq("prog_div", 32'(o_div), 32'(d));
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        testmode         = 1'b0;
        en               = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_clk", 32'(o_clock), 32'd0);
        check_eq("rst_tick", 32'(o_tick), 32'd0);
        check_eq("rst_run", 32'(o_running), 32'd0);
        check_eq("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        check_eq("rst_err", 32'(cfg_if.cfg_err), 32'd0);
        check_eq("rst_div", 32'(o_div), 32'd4);
        reset = 1'b0;

        // Default divisor 4: 1,1,0,0 from the first edge after en
        en = 1'b1;
        run_cycles(4, 0);
        check_eq("run_n4", 32'(o_running), 32'd1);
        run_cycles(4, 0);
        en = 1'b0;
        step();
        check_eq("stop1_clk", 32'(o_clock), 32'd0);
        check_eq("stop1_run", 32'(o_running), 32'd0);

        // Divisor 5 programmed in IDLE
        program_idle(8'd5);
        en = 1'b1;
        run_cycles(5, 0);
        run_cycles(5, 0);
        en = 1'b0;
        step();
        check_eq("stop2_run", 32'(o_running), 32'd0);

        // Maximum divisor 255: 127 high, 128 low
        program_idle(8'd255);
        en = 1'b1;
        run_cycles(255, 0);
        en = 1'b0;
        step();
        check_eq("stop3_run", 32'(o_running), 32'd0);

        // Change 4 -> 6 while running, offered at cnt=1
        program_idle(8'd4);
        en = 1'b1;
        step();
        step();
        check_eq("chg_cnt1_clk", 32'(o_clock), 32'd1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd6;
        step();
        cfg_if.cfg_valid = 1'b0;
        check_eq("chg_ready_c2", 32'(cfg_if.cfg_ready), 32'd0);
        check_eq("chg_div_old", 32'(o_div), 32'd4);
        check_eq("chg_clk_c2", 32'(o_clock), 32'd0);
        step();
        check_eq("chg_ready_c3", 32'(cfg_if.cfg_ready), 32'd0);
        run_cycles(6, 0);
        check_eq("chg_div_new", 32'(o_div), 32'd6);
        check_eq("chg_ready_back", 32'(cfg_if.cfg_ready), 32'd1);

        // Offer 8 in the boundary cycle: applied one period later
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd8;
        step();
        cfg_if.cfg_valid = 1'b0;
        check_eq("bnd_tick", 32'(o_tick), 32'd1);
        check_eq("bnd_div_still6", 32'(o_div), 32'd6);
        check_eq("bnd_ready", 32'(cfg_if.cfg_ready), 32'd0);
        run_cycles(6, 1);
        run_cycles(8, 0);
        check_eq("bnd_div8", 32'(o_div), 32'd8);

        // Illegal divisors 1 and 0
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd1;
        step();
        check_eq("err1", 32'(cfg_if.cfg_err), 32'd1);
        check_eq("err1_tick", 32'(o_tick), 32'd1);
        cfg_if.cfg_div = 8'd0;
        step();
        check_eq("err0", 32'(cfg_if.cfg_err), 32'd1);
        cfg_if.cfg_valid = 1'b0;
        step();
        check_eq("err_clear", 32'(cfg_if.cfg_err), 32'd0);
        check_eq("err_div", 32'(o_div), 32'd8);
        run_cycles(8, 3);
        run_cycles(8, 0);

        // Stop requested at cnt=0 with N=6 completes the period
        en = 1'b0;
        step();
        program_idle(8'd6);
        en = 1'b1;
        step();
        check_eq("stop_c0_tick", 32'(o_tick), 32'd1);
        en = 1'b0;
        run_cycles(6, 1);
        check_eq("stop_late_run", 32'(o_running), 32'd1);
        step();
        check_eq("stop_clk", 32'(o_clock), 32'd0);
        check_eq("stop_run", 32'(o_running), 32'd0);
        step();
        check_eq("stop_hold", 32'(o_clock), 32'd0);
        en = 1'b1;
        step();
        check_eq("restart_clk", 32'(o_clock), 32'd1);
        check_eq("restart_tick", 32'(o_tick), 32'd1);
        check_eq("restart_run", 32'(o_running), 32'd1);

        // Asynchronous reset at cnt=2 with a pending divisor
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd9;
        step();
        cfg_if.cfg_valid = 1'b0;
        check_eq("pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
        step();
        check_eq("pre_rst_clk", 32'(o_clock), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_clk", 32'(o_clock), 32'd0);
        check_eq("arst_run", 32'(o_running), 32'd0);
        check_eq("arst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        check_eq("arst_div", 32'(o_div), 32'd4);
        check_eq("arst_tick", 32'(o_tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_cycles(4, 0);
        check_eq("arst_pend_lost", 32'(o_div), 32'd4);

        // Testmode bypass: o_clock follows i_clock, tick keeps cadence
        testmode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("tm_hi_%0d", i), 32'(o_clock), 32'd1);
            @(negedge clk);
            check_eq($sformatf("tm_lo_%0d", i), 32'(o_clock), 32'd0);
            check_eq($sformatf("tm_tick_%0d", i), 32'(o_tick), 32'(i == 0));
        end
        testmode = 1'b0;
        run_cycles(4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
